// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - shared seven-segment glyph constants and types
// Glyphs are {g,f,e,d,c,b,a} with a lit segment as 1; the sevenseg driver uses the same table.
package sevenseg_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [6:0] glyph_t;

  localparam glyph_t GLYPH_0 = 7'h3F;
  localparam glyph_t GLYPH_1 = 7'h06;
  localparam glyph_t GLYPH_2 = 7'h5B;
  localparam glyph_t GLYPH_3 = 7'h4F;
  localparam glyph_t GLYPH_4 = 7'h66;
  localparam glyph_t GLYPH_5 = 7'h6D;
  localparam glyph_t GLYPH_6 = 7'h7D;
  localparam glyph_t GLYPH_7 = 7'h07;
  localparam glyph_t GLYPH_8 = 7'h7F;
  localparam glyph_t GLYPH_9 = 7'h6F;
  localparam glyph_t GLYPH_A = 7'h77;
  localparam glyph_t GLYPH_B = 7'h7C;
  localparam glyph_t GLYPH_C = 7'h39;
  localparam glyph_t GLYPH_D = 7'h5E;
  localparam glyph_t GLYPH_E = 7'h79;
  localparam glyph_t GLYPH_F = 7'h71;

endpackage

// File: rtl/sevenseg_glyph_decode.sv
// rtl/sevenseg_glyph_decode.sv - glyph to hex nibble lookup
// Purely combinational; hit is low for any pattern outside the sixteen hex glyphs.
module sevenseg_glyph_decode
  import sevenseg_pkg::*;
(
  input  glyph_t     glyph,
  output logic [3:0] nibble,
  output logic       hit
);

  always_comb begin
    nibble = 4'h0;
    hit    = 1'b1;
    case (glyph)
      GLYPH_0: nibble = 4'h0;
      GLYPH_1: nibble = 4'h1;
      GLYPH_2: nibble = 4'h2;
      GLYPH_3: nibble = 4'h3;
      GLYPH_4: nibble = 4'h4;
      GLYPH_5: nibble = 4'h5;
      GLYPH_6: nibble = 4'h6;
      GLYPH_7: nibble = 4'h7;
      GLYPH_8: nibble = 4'h8;
      GLYPH_9: nibble = 4'h9;
      GLYPH_A: nibble = 4'hA;
      GLYPH_B: nibble = 4'hB;
      GLYPH_C: nibble = 4'hC;
      GLYPH_D: nibble = 4'hD;
      GLYPH_E: nibble = 4'hE;
      GLYPH_F: nibble = 4'hF;
      default: hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/sevenseg_capture.sv
// rtl/sevenseg_capture.sv - recovers four hex digits from a multiplexed seven-segment scan
// Define SEVENSEG_CAPTURE_DP_EN to capture the decimal point per digit.
module sevenseg_capture
  import sevenseg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       e,
  input  logic       f,
  input  logic       g,
  input  logic       dp,
  input  logic [3:0] an,
  output logic [3:0] out0,
  output logic [3:0] out1,
  output logic [3:0] out2,
  output logic [3:0] out3,
  output logic [3:0] valid,
  output logic [3:0] dp_out,
  output logic       frame,
  output logic       err
);

  glyph_t                seg_in;
  glyph_t                seg_r;
  logic [NUM_DIGITS-1:0] an_r;
  logic [7:0]            cnt;
  logic                  captured;
  logic                  same;
  logic                  active;
  logic                  capture;
  logic [1:0]            idx;
  logic [3:0]            nibble;
  logic                  hit;
  logic [NUM_DIGITS-1:0] seen;
  logic [NUM_DIGITS-1:0] seen_next;
  logic [3:0]            out_q [NUM_DIGITS];

  assign seg_in = ~{g, f, e, d, c, b, a};

  always_ff @(posedge clock) begin
    if (reset) begin
      an_r  <= '1;
      seg_r <= '0;
    end else begin
      an_r  <= an;
      seg_r <= seg_in;
    end
  end

  // The incoming sample is compared with the registered one, so a run of S+1
  // identical samples completes on the edge that also loads the outputs.
`ifdef SEVENSEG_CAPTURE_DP_EN
  logic dp_r;

  always_ff @(posedge clock) begin
    if (reset) dp_r <= 1'b0;
    else       dp_r <= ~dp;
  end

  assign same = (an == an_r) && (seg_in == seg_r) && (~dp == dp_r);
`else
  logic unused_dp;

  assign unused_dp = dp;
  assign same      = (an == an_r) && (seg_in == seg_r);
`endif

  always_comb begin
    active = 1'b0;
    idx    = 2'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (an_r == ~(NUM_DIGITS'(1) << i)) begin
        active = 1'b1;
        idx    = 2'(i);
      end
    end
  end

  assign capture = same && active && !captured && (cnt == 8'(STABLE_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt      <= 8'd0;
      captured <= 1'b0;
    end else begin
      if (same && active) begin
        if (cnt != 8'(STABLE_CYCLES)) cnt <= cnt + 8'd1;
      end else begin
        cnt <= 8'd0;
      end
      if (an != an_r)   captured <= 1'b0;
      else if (capture) captured <= 1'b1;
    end
  end

  sevenseg_glyph_decode u_decode (
    .glyph  (seg_r),
    .nibble (nibble),
    .hit    (hit)
  );

  assign seen_next = seen | (NUM_DIGITS'(1) << idx);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) out_q[i] <= 4'h0;
      valid <= '0;
      seen  <= '0;
      frame <= 1'b0;
      err   <= 1'b0;
    end else begin
      frame <= 1'b0;
      err   <= 1'b0;
      if (capture) begin
        if (hit) begin
          out_q[idx] <= nibble;
          valid[idx] <= 1'b1;
          if (seen_next == '1) begin
            frame <= 1'b1;
            seen  <= '0;
          end else begin
            seen  <= seen_next;
          end
        end else begin
          valid[idx] <= 1'b0;
          err        <= 1'b1;
        end
      end
    end
  end

`ifdef SEVENSEG_CAPTURE_DP_EN
  always_ff @(posedge clock) begin
    if (reset)        dp_out      <= '0;
    else if (capture) dp_out[idx] <= dp_r;
  end
`else
  assign dp_out = '0;
`endif

  assign out0 = out_q[0];
  assign out1 = out_q[1];
  assign out2 = out_q[2];
  assign out3 = out_q[3];

endmodule

// File: tb/tb_sevenseg_capture.sv
// tb/tb_sevenseg_capture.sv - self-checking bench for sevenseg_capture
// Reference model works on runs of identical pin samples and a set of seen digits.
module tb_sevenseg_capture;

  localparam int S = 4;
`ifdef SEVENSEG_CAPTURE_DP_EN
  localparam bit DP_EN = 1'b1;
`else
  localparam bit DP_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       rst = 1'b0;
  logic       a, b, c, d, e, f, g, dp;
  logic [3:0] an;
  logic [3:0] out0, out1, out2, out3, valid, dp_out;
  logic       frame, err;

  sevenseg_capture #(.STABLE_CYCLES(S)) dut (
    .clock(clock), .reset(rst),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .dp(dp), .an(an),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .valid(valid), .dp_out(dp_out), .frame(frame), .err(err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc_bad = 0;
  int dut_frames = 0, dut_errs = 0;
  int m_frames = 0, m_errs = 0;

  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic [3:0]  cur_an = 4'hF;
  logic [6:0]  cur_code = 7'h00;
  logic        cur_dp = 1'b0;

  logic [3:0]  m_out [4];
  logic [3:0]  m_valid = '0, m_dp = '0, m_seen = '0;
  logic        m_frame = 1'b0, m_err = 1'b0;
  logic [11:0] prev_key = '0;
  bit          prev_ok = 1'b0, an_capt = 1'b0;
  int          run = 0;

  function automatic logic [23:0] dut_vec();
    return {out3, out2, out1, out0, valid, dp_out};
  endfunction

  function automatic logic [23:0] mdl_vec();
    return {m_out[3], m_out[2], m_out[1], m_out[0], m_valid, m_dp};
  endfunction

  task automatic set_pins(input logic [3:0] an_v, input logic [6:0] code, input logic dp_lit);
    cur_an = an_v; cur_code = code; cur_dp = dp_lit;
    an = an_v;
    {g, f, e, d, c, b, a} = ~code;
    dp = ~dp_lit;
  endtask

  task automatic model_step();
    logic [11:0] key;
    logic [3:0]  one_hot;
    int dig, nib;
    m_frame = 1'b0;
    m_err   = 1'b0;
    if (rst) begin
      for (int i = 0; i < 4; i++) m_out[i] = 4'h0;
      m_valid = '0; m_dp = '0; m_seen = '0;
      prev_ok = 1'b0; an_capt = 1'b0; run = 0;
      return;
    end
    key = {cur_an, cur_code, DP_EN ? cur_dp : 1'b0};
    if (!prev_ok || key[11:8] != prev_key[11:8]) an_capt = 1'b0;
    run = (prev_ok && key == prev_key) ? run + 1 : 1;
    prev_key = key;
    prev_ok  = 1'b1;
    dig = -1;
    for (int i = 0; i < 4; i++) begin
      one_hot = 4'b0001 << i;
      if (cur_an == ~one_hot) dig = i;
    end
    if (dig >= 0 && run == S + 1 && !an_capt) begin
      an_capt = 1'b1;
      nib = -1;
      for (int j = 0; j < 16; j++) if (glyph_tab[j] == cur_code) nib = j;
      if (DP_EN) m_dp[dig] = cur_dp;
      if (nib >= 0) begin
        m_out[dig]   = nib[3:0];
        m_valid[dig] = 1'b1;
        m_seen[dig]  = 1'b1;
        if (m_seen == 4'hF) begin
          m_frame = 1'b1;
          m_seen  = '0;
          m_frames++;
        end
      end else begin
        m_valid[dig] = 1'b0;
        m_err = 1'b1;
        m_errs++;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    #1;
    if ({frame, err} !== {m_frame, m_err} || dut_vec() !== mdl_vec()) cyc_bad++;
    if (frame) dut_frames++;
    if (err) dut_errs++;
  endtask

  task automatic dwell(input logic [3:0] an_v, input logic [6:0] code, input logic dp_lit, input int n);
    set_pins(an_v, code, dp_lit);
    repeat (n) cycle();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    set_pins(4'b1110, 7'h7F, 1'b1);
    do_reset(3);
    checks++;
    if (dut_vec() !== 24'h0 || frame !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got vec=%h frame=%b err=%b, want vec=000000 frame=0 err=0", dut_vec(), frame, err);
    end
  endtask

  task automatic test_short_dwell();
    dwell(4'b1111, 7'h00, 1'b0, 4);
    dwell(4'b1110, 7'h06, 1'b0, S);
    dwell(4'b1111, 7'h00, 1'b0, 4);
    checks++;
    if (out0 !== 4'h0 || valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL short_dwell: got out0=%h valid0=%b, want out0=0 valid0=0", out0, valid[0]);
    end
    dwell(4'b1110, 7'h06, 1'b0, S + 1);
    checks++;
    if (out0 !== 4'h1 || valid[0] !== 1'b1) begin
      errors++;
      $display("FAIL min_dwell: got out0=%h valid0=%b, want out0=1 valid0=1", out0, valid[0]);
    end
  endtask

  task automatic test_normal_scan();
    int f0, fpos;
    do_reset(2);
    f0 = dut_frames;
    dwell(4'b1110, 7'h06, 1'b0, 16);
    dwell(4'b1101, 7'h5B, 1'b0, 16);
    dwell(4'b1011, 7'h7F, 1'b0, 16);
    set_pins(4'b0111, 7'h6F, 1'b0);
    fpos = 0;
    for (int k = 1; k <= 16; k++) begin
      cycle();
      if (frame) fpos = k;
    end
    checks++;
    if ({out3, out2, out1, out0} !== 16'h9821 || valid !== 4'hF) begin
      errors++;
      $display("FAIL normal_scan_digits: got %h%h%h%h valid=%b, want 9821 valid=1111", out3, out2, out1, out0, valid);
    end
    checks++;
    if (dut_frames - f0 !== 1 || fpos !== 5) begin
      errors++;
      $display("FAIL normal_scan_frame: got count=%0d at cycle %0d, want count=1 at cycle 5", dut_frames - f0, fpos);
    end
  endtask

  task automatic test_bad_glyph();
    int f0, e0;
    f0 = dut_frames; e0 = dut_errs;
    dwell(4'b1011, 7'h00, 1'b0, 16);
    checks++;
    if (dut_errs - e0 !== 1 || valid !== 4'b1011 || out2 !== 4'h8 || dut_frames - f0 !== 0) begin
      errors++;
      $display("FAIL bad_glyph: got errs=%0d valid=%b out2=%h frames=%0d, want errs=1 valid=1011 out2=8 frames=0",
               dut_errs - e0, valid, out2, dut_frames - f0);
    end
  endtask

  task automatic test_idle();
    int f0, e0;
    f0 = dut_frames; e0 = dut_errs;
    dwell(4'b1100, 7'h7F, 1'b0, 32);
    dwell(4'b1111, 7'h7F, 1'b0, 32);
    checks++;
    if ({out3, out2, out1, out0} !== 16'h9821 || valid !== 4'b1011 || dut_errs - e0 !== 0 || dut_frames - f0 !== 0) begin
      errors++;
      $display("FAIL idle_anodes: got %h%h%h%h valid=%b errs=%0d frames=%0d, want 9821 valid=1011 errs=0 frames=0",
               out3, out2, out1, out0, valid, dut_errs - e0, dut_frames - f0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int f0;
    dwell(4'b1110, 7'h3F, 1'b0, 8);
    dwell(4'b1101, 7'h66, 1'b0, 8);
    do_reset(1);
    checks++;
    if (dut_vec() !== 24'h0) begin
      errors++;
      $display("FAIL reset_mid_frame_clear: got vec=%h, want 000000", dut_vec());
    end
    f0 = dut_frames;
    dwell(4'b1011, 7'h77, 1'b0, 8);
    dwell(4'b0111, 7'h7C, 1'b0, 8);
    dwell(4'b1110, 7'h39, 1'b0, 8);
    checks++;
    if (dut_frames - f0 !== 0) begin
      errors++;
      $display("FAIL reset_mid_frame_early: got frames=%0d, want 0", dut_frames - f0);
    end
    dwell(4'b1101, 7'h5E, 1'b0, 8);
    checks++;
    if (dut_frames - f0 !== 1 || {out3, out2, out1, out0} !== 16'hBAdC) begin
      errors++;
      $display("FAIL reset_mid_frame_fourth: got frames=%0d digits=%h%h%h%h, want frames=1 digits=badc",
               dut_frames - f0, out3, out2, out1, out0);
    end
    dwell(4'b1110, 7'h71, 1'b0, 3);
    do_reset(1);
    dwell(4'b1110, 7'h71, 1'b0, S - 1);
    checks++;
    if (valid !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_dwell: got valid=%b, want 0000", valid);
    end
    dwell(4'b1110, 7'h71, 1'b0, 2);
    checks++;
    if (valid !== 4'b0001 || out0 !== 4'hF) begin
      errors++;
      $display("FAIL reset_fresh_run: got valid=%b out0=%h, want 0001 F", valid, out0);
    end
  endtask

  task automatic test_dp();
    logic [3:0] want;
    want = DP_EN ? 4'b0010 : 4'b0000;
    do_reset(2);
    dwell(4'b1110, 7'h06, 1'b0, 10);
    dwell(4'b1101, 7'h5B, 1'b1, 10);
    dwell(4'b1011, 7'h4F, 1'b0, 10);
    dwell(4'b0111, 7'h66, 1'b0, 10);
    checks++;
    if (dp_out !== want) begin
      errors++;
      $display("FAIL decimal_point: got dp_out=%b, want %b", dp_out, want);
    end
  endtask

  task automatic test_random();
    logic [3:0] an_list [7] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1100, 4'b1111, 4'b0000};
    logic [6:0] code;
    int bad0, mf0, df0, me0, de0;
    bad0 = cyc_bad; mf0 = m_frames; df0 = dut_frames; me0 = m_errs; de0 = dut_errs;
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 99) < 3) do_reset($urandom_range(1, 2));
      code = ($urandom_range(0, 3) != 0) ? glyph_tab[$urandom_range(0, 15)] : 7'($urandom);
      dwell(an_list[$urandom_range(0, 6)], code, 1'($urandom), $urandom_range(1, 10));
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++;
        $display("FAIL random_dwell_%0d: got vec=%h, want %h", k, dut_vec(), mdl_vec());
      end
    end
    checks++;
    if (cyc_bad - bad0 !== 0) begin
      errors++;
      $display("FAIL random_per_cycle: got %0d mismatching cycles, want 0", cyc_bad - bad0);
    end
    checks++;
    if (dut_frames - df0 !== m_frames - mf0 || dut_errs - de0 !== m_errs - me0) begin
      errors++;
      $display("FAIL random_pulses: got frames=%0d errs=%0d, want frames=%0d errs=%0d",
               dut_frames - df0, dut_errs - de0, m_frames - mf0, m_errs - me0);
    end
  endtask

  initial begin
    int bad0;
    for (int i = 0; i < 4; i++) m_out[i] = 4'h0;
    set_pins(4'hF, 7'h00, 1'b0);
    test_reset();
    bad0 = cyc_bad;
    test_short_dwell();
    test_normal_scan();
    test_bad_glyph();
    test_idle();
    test_reset_mid_frame();
    test_dp();
    checks++;
    if (cyc_bad - bad0 !== 0) begin
      errors++;
      $display("FAIL directed_per_cycle: got %0d mismatching cycles, want 0", cyc_bad - bad0);
    end
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sevenseg_capture.md
# sevenseg_capture

Receive side of the multiplexed seven-segment display interface. Monitors the segment lines (a–g, dp) and the anode lines (an) that a multiplexing display driver produces, and recovers the four displayed hex digits. The block sits on the board-to-board capture path and in self-check benches, opposite the `sevenseg` driver. It filters scan transitions with a stability counter and flags undecodable glyphs.

## Interface
Parameters:
- `STABLE_CYCLES`, default 4: consecutive identical samples required before a digit is captured. Legal range is 2–255.

Ports:
- `clock`, in, 1: single system clock. All logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `a`,`b`,`c`,`d`,`e`,`f`,`g`, in, 1 each: segment lines, active-low.
- `dp`, in, 1: decimal point line, active-low.
- `an`, in, 4: anode selects, active-low. `an[0]` selects digit 0.
- `out0`,`out1`,`out2`,`out3`, out, 4 each: last captured nibble per digit.
- `valid`, out, 4: per-digit flag. A bit is 1 when the last capture of that digit decoded successfully.
- `dp_out`, out, 4: captured decimal point per digit, active-high.
- `frame`, out, 1: one-cycle pulse when all four digits have been captured since the last pulse.
- `err`, out, 1: one-cycle pulse on a stable but undecodable glyph.

## Operation
- **Input stage.** All pins are registered once into `seg_r` = {g,f,e,d,c,b,a} (inverted to active-high), `dp_r` (inverted) and `an_r`.
- **Active digit.** Exactly one bit of `an_r` is low. The digit index is that bit's position. Any other `an_r` value (none low, or several low) is idle: the counter clears and no capture happens.
- **Stability counter.**
  - Increments while {an_r, seg_r, dp_r} equals the previous cycle's registered value and a digit is active.
  - Clears to 0 on any difference.
  - Saturates at `STABLE_CYCLES`.
- **Capture.**
  - Fires once per dwell, on the cycle the counter reaches `STABLE_CYCLES-1`.
  - A `captured` flag blocks a repeat capture until `an_r` changes.
- **Decode.** Glyph codes are {g..a} active-high:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- **Good glyph.** `outN` takes the nibble, `valid[N]` is set to 1, and bit N of `seen` is set.
- **Bad glyph** (any other code, including blank 00):
  - `outN` holds its value and `valid[N]` is set to 0.
  - `err` pulses.
  - `seen` is unchanged.
- **Frame.**
  - The cycle `seen` would become 1111, `frame` pulses and `seen` clears to 0000 on the same edge.
  - Recapturing an already-seen digit does not retrigger `frame`.
- **Reset.** `out0..3`=0, `valid`=0000, `dp_out`=0000, `frame`=0, `err`=0, `seen`=0, counter=0, `captured`=0.
- **Reset mid-dwell.** The dwell in progress is discarded. Capture requires a fresh `STABLE_CYCLES` run after reset deasserts.

## Timing
- **Capture latency.** Pins settle before edge E0 and are first registered at E0. With `STABLE_CYCLES`=S, `outN`, `valid`, `dp_out`, `err` and `frame` are visible after edge E0+S. With S=4, pins stable from edge 0 give outputs after edge 4.
- **Minimum dwell.** An anode must be held at least S+1 cycles to be captured. A dwell of S or fewer cycles is ignored.
- **Pulses.** `frame` and `err` are high for exactly one cycle. Both may pulse on the same cycle only if the last missing digit is good and some other event is bad, which is impossible, so they never coincide.
- **Outputs.** All outputs are registered. There are no combinational input-to-output paths.

## Configuration
- `SEVENSEG_CAPTURE_DP_EN` defined:
  - `dp_r` takes part in the stability comparison.
  - `dp_out[N]` is loaded on every capture of digit N, good or bad glyph.
- Not defined:
  - `dp` is ignored.
  - `dp_out` is tied to 0000.
  - Stability compares only `an_r` and `seg_r`.

## Structure
- Shared package `sevenseg_pkg` holds:
  - `NUM_DIGITS`=4.
  - The sixteen glyph constants (`GLYPH_0`..`GLYPH_F`, 7-bit, {g..a} active-high).
  - The `glyph_t` 7-bit typedef.
  
  The `sevenseg` driver reuses the same constants.
- Sub-module `sevenseg_glyph_decode`: combinational, glyph_t in, nibble plus hit flag out. It is instantiated once on `seg_r`.
- The top holds the input registers, stability counter, capture and `seen` logic, and output registers.

## Test plan
1. **Normal scan.** Scan digits 1,2,8,9 on `an`=1110,1101,1011,0111 with a 16-cycle dwell each and S=4. Expect `out0`=1, `out1`=2, `out2`=8, `out3`=9, `valid`=1111, and one `frame` pulse 5 cycles into the digit-3 dwell.
2. **Short dwell.** Hold digit 0 with glyph 06 for 4 cycles, then switch. Expect no capture, `out0` still 0, `valid[0]`=0.
3. **Bad glyph.** After test 1, show blank (all segments high) on digit 2 for 16 cycles. Expect `err` pulses once, `valid[2]`=0, `out2` still 8, no `frame`.
4. **Idle anodes.** `an`=1100 or 1111 for 32 cycles with glyph 7F. Expect no capture, no `err`, outputs unchanged.
5. **Reset mid-frame.** Capture digits 0 and 1, then assert `reset` for 1 cycle. Expect all outputs 0. `frame` fires only after four further captures.
6. **Decimal point.** With `SEVENSEG_CAPTURE_DP_EN`, `dp` low only on digit 1 gives `dp_out`=0010. Without the macro, the same stimulus gives `dp_out`=0000.
